// File: rtl/lcd_hex_formatter.sv
// lcd_hex_formatter: renders NFIELD hex fields of NIB nibbles each into a
// LINE_CHARS-character LCD string laid over a background template.
// A render starts when any field differs from the last captured snapshot
// or when force_lvl rises. The finished string is offered to the display
// driver through a req/ack handshake.
// The force input is named force_lvl because "force" is a reserved word.
// Build option: define LCD_HEX_UPPER_EN to get upper-case 'A'-'F' digits.
// Without it the digits are lower-case 'a'-'f'.
// Field slots that would fall past the end of the line are not written.
// The scan still takes NFIELD*NIB cycles, so the latency does not change.
module lcd_hex_formatter #(
    parameter int NFIELD     = 4,
    parameter int NIB        = 8,
    parameter int LINE_CHARS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*LINE_CHARS-1:0]    tmpl,
    input  logic [NFIELD*NIB*4-1:0]    fields,
    input  logic                       force_lvl,
    input  logic                       upd_ack,
    output logic [8*LINE_CHARS-1:0]    strdata,
    output logic                       upd_req,
    output logic                       busy
);

    localparam int NTOT  = NFIELD * NIB;
    localparam int IW    = (NTOT > 1) ? $clog2(NTOT) : 1;
    localparam int PW    = $clog2(NFIELD * (NIB + 1) + 1);
    localparam int JW    = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, REQ} state_t;

    state_t            state, state_nxt;
    logic [NTOT*4-1:0] snapshot;
    logic              force_q;
    logic              pending;
    logic              evt;
    logic [IW-1:0]     idx;
    logic [JW-1:0]     nib_j;
    logic [PW-1:0]     pos;
    logic [3:0]        cur_nib;
    logic              scan_last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
`ifdef LCD_HEX_UPPER_EN
        return 8'h37 + {4'h0, n};
`else
        return 8'h57 + {4'h0, n};
`endif
    endfunction

    // Flat nibble idx counts from the MSB, so field 0 / nibble 0 comes out first.
    assign cur_nib   = snapshot[(NTOT-1-int'(idx))*4 +: 4];
    assign scan_last = (idx == IW'(NTOT-1));

    // The change in the LOAD cycle is the one being captured.
    // Only a force rise can re-arm pending during LOAD.
    assign evt = (force_lvl & ~force_q) | ((fields != snapshot) & (state != LOAD));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        upd_req   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (pending) state_nxt = LOAD;
            end
            LOAD: state_nxt = SCAN;
            SCAN: if (scan_last) state_nxt = REQ;
            REQ: begin
                upd_req = 1'b1;
                if (upd_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Event tracking, snapshot capture and character-by-character render
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strdata  <= {LINE_CHARS{8'h20}};
            snapshot <= '0;
            force_q  <= 1'b0;
            pending  <= 1'b1;
            idx      <= '0;
            nib_j    <= '0;
            pos      <= '0;
        end else begin
            force_q <= force_lvl;
            if (evt)                pending <= 1'b1;
            else if (state == LOAD) pending <= 1'b0;
            case (state)
                LOAD: begin
                    snapshot <= fields;
                    strdata  <= tmpl;
                    idx      <= '0;
                    nib_j    <= '0;
                    pos      <= '0;
                end
                SCAN: begin
                    if (int'(pos) < LINE_CHARS)
                        strdata[(LINE_CHARS-1-int'(pos))*8 +: 8] <= hex_char(cur_nib);
                    idx <= idx + IW'(1);
                    // At the end of a field, step over the template separator char.
                    if (nib_j == JW'(NIB-1)) begin
                        nib_j <= '0;
                        pos   <= pos + PW'(2);
                    end else begin
                        nib_j <= nib_j + JW'(1);
                        pos   <= pos + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hex_formatter.sv
// Testbench for lcd_hex_formatter with the default parameters (4 x 8 nibbles, 32 chars).
// Expected strings are written out by hand. Field 3 shows only its first 5 nibbles
// because it runs off the end of the line.
module tb_lcd_hex_formatter;

    localparam logic [255:0] DASH  = {32{8'h2d}};
    localparam logic [255:0] SPACE = {32{8'h20}};
    localparam logic [255:0] TALT  = "ABCDEFGHIJKLMNOPQRSTUVWXYZ<>[]{}";

    typedef struct {
        logic [255:0] tm;
        logic [127:0] f;
        logic [255:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         frc = 1'b0;
    logic         upd_ack = 1'b1;
    logic [255:0] tmpl;
    logic [127:0] fields;
    logic [255:0] strdata;
    logic         upd_req, busy;

    int   n_cmp = 0;
    int   n_err = 0;
    int   req_cnt = 0;
    logic req_q = 1'b0;
    vec_t vt[4];

    lcd_hex_formatter dut (
        .clk       (clk),
        .rst       (rst),
        .tmpl      (tmpl),
        .fields    (fields),
        .force_lvl (frc),
        .upd_ack   (upd_ack),
        .strdata   (strdata),
        .upd_req   (upd_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count rising edges of upd_req (pulses)
    always @(negedge clk) begin
        req_q <= upd_req;
        if (upd_req && !req_q) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string nm, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!upd_req && cyc < 200);
        if (!upd_req) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: upd_req timeout after %0d cycles, want 1", nm, cyc);
        end
    endtask

    task automatic wait_busy(input string nm);
        int cyc = 0;
        while (!busy && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: busy timeout got 0 want 1", nm);
        end
    endtask

    initial begin
        int           c, r0;
        logic         ok;
        logic [255:0] s;

        tmpl   = DASH;
        fields = '0;

        vt[0].tm = DASH; vt[0].f = {32'h1234ABCD, 32'h0, 32'h0, 32'h0};
        vt[1].tm = DASH; vt[1].f = {32'hFFFFFFFF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
        vt[2].tm = DASH; vt[2].f = {32'h0, 32'hA5A5A5A5, 32'h0000000F, 32'h9000000A};
        vt[3].tm = TALT; vt[3].f = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
`ifdef LCD_HEX_UPPER_EN
        vt[0].exp = "1234ABCD-00000000-00000000-00000";
        vt[1].exp = "FFFFFFFF-01234567-89ABCDEF-FEDCB";
        vt[2].exp = "00000000-A5A5A5A5-0000000F-90000";
`else
        vt[0].exp = "1234abcd-00000000-00000000-00000";
        vt[1].exp = "ffffffff-01234567-89abcdef-fedcb";
        vt[2].exp = "00000000-a5a5a5a5-0000000f-90000";
`endif
        vt[3].exp = "11111111I22222222R33333333<44444";

        // Reset state
        repeat (3) tick();
        chk("rst_str", strdata, SPACE);
        chk("rst_req", {255'd0, upd_req}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);

        // Automatic first render after release
        rst = 1'b1;
        wait_req("t1", c);
        chk("t1_lat", c, 34);
        chk("t1_str", strdata, "00000000-00000000-00000000-00000");
        chk("t1_busy", {255'd0, busy}, 256'd1);
        repeat (5) tick();

        // Table vectors: one render each
        for (int i = 0; i < 4; i++) begin
            tmpl   = vt[i].tm;
            fields = vt[i].f;
            r0     = req_cnt;
            wait_req($sformatf("vec%0d", i), c);
            chk($sformatf("vec%0d_str", i), strdata, vt[i].exp);
            repeat (50) tick();
            chk($sformatf("vec%0d_cnt", i), req_cnt - r0, 1);
        end

        // Field change mid-scan: old value now, new value in a second render
        fields = {32'h55555555, 32'h22222222, 32'h33333333, 32'h44444444};
        r0     = req_cnt;
        wait_busy("t3_busy");
        tick();
        repeat (5) tick();
        fields[95:64] = 32'h66666666;
        wait_req("t3a", c);
        chk("t3_old", strdata, "55555555I22222222R33333333<44444");
        wait_req("t3b", c);
        chk("t3_new", strdata, "55555555I66666666R33333333<44444");
        repeat (50) tick();
        chk("t3_cnt", req_cnt - r0, 2);

        // Ack withheld: REQ holds, string frozen even though a field changes
        upd_ack        = 1'b0;
        fields[127:96] = 32'h0BADF00D;
        wait_req("t4", c);
`ifdef LCD_HEX_UPPER_EN
        chk("t4_str", strdata, "0BADF00DI66666666R33333333<44444");
`else
        chk("t4_str", strdata, "0badf00dI66666666R33333333<44444");
`endif
        s             = strdata;
        fields[63:32] = 32'h77777777;
        ok            = 1'b1;
        repeat (100) begin
            tick();
            if (!(upd_req === 1'b1 && busy === 1'b1 && strdata === s)) ok = 1'b0;
        end
        chk("t4_hold", {255'd0, ok}, 256'd1);
        upd_ack = 1'b1;
        tick();
        chk("t4_idle", {255'd0, busy}, 256'd0);
        chk("t4_drop", {255'd0, upd_req}, 256'd0);
        wait_req("t4b", c);
`ifdef LCD_HEX_UPPER_EN
        s = "0BADF00DI66666666R77777777<44444";
`else
        s = "0badf00dI66666666R77777777<44444";
`endif
        chk("t4_str2", strdata, s);

        // Force: level held counts once, a new rise counts again
        repeat (10) tick();
        r0  = req_cnt;
        frc = 1'b1;
        repeat (50) tick();
        chk("t5_cnt1", req_cnt - r0, 1);
        chk("t5_str", strdata, s);
        frc = 1'b0;
        repeat (3) tick();
        frc = 1'b1;
        repeat (50) tick();
        chk("t5_cnt2", req_cnt - r0, 2);
        frc = 1'b0;
        repeat (5) tick();

        // Reset in the middle of a scan
        fields = {32'h87654321, 32'h66666666, 32'h77777777, 32'h44444444};
        wait_busy("t6_busy");
        tick();
        repeat (10) tick();
        chk("t6_scan", {255'd0, busy}, 256'd1);
        rst = 1'b0;
        #1;
        chk("t6_str", strdata, SPACE);
        chk("t6_req", {255'd0, upd_req}, 256'd0);
        chk("t6_busy0", {255'd0, busy}, 256'd0);
        repeat (3) tick();
        rst = 1'b1;
        wait_req("t6", c);
        chk("t6_lat", c, 34);
        chk("t6_str2", strdata, "87654321I66666666R77777777<44444");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
